// File: rtl/wstab_pkg.sv
// wstab_pkg: shared FSM state type and default parameter values for the
// weight stabilizer slice.
package wstab_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        LOCKED,
        RELEASING
    } wstab_state_e;

    localparam int unsigned STABLE_CNT = 4;
    localparam int unsigned TOL        = 8;
    localparam int unsigned EMPTY_THR  = 5;
    localparam int unsigned EMPTY_CNT  = 2;
    localparam int unsigned SETTLE_TMO = 64;

endpackage

// File: rtl/weight_stabilizer_if.sv
// weight_stabilizer_if: scale sample input and stabilized weight output bundle.
// master = sample source / weight consumer, slave = stabilizer.
interface weight_stabilizer_if;

    logic [11:0] raw_weight;
    logic        raw_valid;
    logic [11:0] weight;
    logic        locked;
    logic        pkg_strobe;
    logic        settle_err;

    modport master (
        output raw_weight, raw_valid,
        input  weight, locked, pkg_strobe, settle_err
    );

    modport slave (
        input  raw_weight, raw_valid,
        output weight, locked, pkg_strobe, settle_err
    );

endinterface

// File: rtl/wstab_window_cmp.sv
// wstab_window_cmp: |a - b| <= TOL, difference formed at 13 bits so that
// extreme operands (e.g. 0 vs 4095) never wrap into the window.
module wstab_window_cmp #(
    parameter int unsigned TOL = wstab_pkg::TOL
) (
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    output logic        in_tol_o
);
    import wstab_pkg::*;

    logic [12:0] diff_d;

    // Absolute difference and window compare
    always_comb begin
        diff_d   = (a_i >= b_i) ? ({1'b0, a_i} - {1'b0, b_i})
                                : ({1'b0, b_i} - {1'b0, a_i});
        in_tol_o = (diff_d <= 13'(TOL));
    end

endmodule

// File: rtl/weight_stabilizer.sv
// weight_stabilizer: locks a scale reading once STABLE_CNT consecutive valid
// samples stay within TOL of a reference, holds it until EMPTY_CNT consecutive
// empty samples are seen, and reports weight 0 whenever nothing is locked.
// Optional settle timeout enabled by macro WSTAB_TIMEOUT_EN.
module weight_stabilizer #(
    parameter int unsigned STABLE_CNT = wstab_pkg::STABLE_CNT,
    parameter int unsigned TOL        = wstab_pkg::TOL,
    parameter int unsigned EMPTY_THR  = wstab_pkg::EMPTY_THR,
    parameter int unsigned EMPTY_CNT  = wstab_pkg::EMPTY_CNT
`ifdef WSTAB_TIMEOUT_EN
    ,
    parameter int unsigned SETTLE_TMO = wstab_pkg::SETTLE_TMO
`endif
) (
    input  logic                clk,
    input  logic                reset,
    weight_stabilizer_if.slave  bus
);
    import wstab_pkg::*;

    localparam int unsigned RW = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
    localparam int unsigned EW = (EMPTY_CNT < 2) ? 1 : $clog2(EMPTY_CNT + 1);
    localparam logic [RW-1:0] RUN_LOCK = RW'(STABLE_CNT);
    localparam logic [EW-1:0] ECNT_REL = EW'(EMPTY_CNT);

    wstab_state_e  state_q;
    logic [11:0]   ref_q;
    logic [11:0]   weight_q;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_inc_d;
    logic [EW-1:0] ecnt_q;
    logic [EW-1:0] ecnt_inc_d;
    logic          locked_q;
    logic          strobe_q;
    logic          empty_d;
    logic          in_tol_d;
    logic          tmo_fire_d;

    assign empty_d = (bus.raw_weight <= 12'(EMPTY_THR));

    wstab_window_cmp #(.TOL(TOL)) u_cmp (
        .a_i      (bus.raw_weight),
        .b_i      (ref_q),
        .in_tol_o (in_tol_d)
    );

    // Saturating increments of the run and empty counters
    always_comb begin
        run_inc_d  = (run_q == '1)  ? run_q  : run_q + RW'(1);
        ecnt_inc_d = (ecnt_q == '1) ? ecnt_q : ecnt_q + EW'(1);
    end

    // Main FSM with registered outputs; only valid samples advance it, the
    // strobe self-clears and the optional timeout acts every clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ref_q    <= '0;
            weight_q <= '0;
            run_q    <= '0;
            ecnt_q   <= '0;
            locked_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (tmo_fire_d) begin
                state_q <= IDLE;
                run_q   <= '0;
            end else if (bus.raw_valid) begin
                case (state_q)
                    IDLE: begin
                        if (!empty_d) begin
                            ref_q <= bus.raw_weight;
                            if (STABLE_CNT <= 1) begin
                                state_q  <= LOCKED;
                                weight_q <= bus.raw_weight;
                                locked_q <= 1'b1;
                                strobe_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                state_q <= SETTLING;
                                run_q   <= RW'(1);
                            end
                        end
                    end
                    SETTLING: begin
                        if (empty_d) begin
                            state_q <= IDLE;
                            run_q   <= '0;
                        end else if (in_tol_d) begin
                            if (run_inc_d >= RUN_LOCK) begin
                                state_q  <= LOCKED;
                                weight_q <= ref_q;
                                locked_q <= 1'b1;
                                strobe_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                run_q <= run_inc_d;
                            end
                        end else begin
                            ref_q <= bus.raw_weight;
                            run_q <= RW'(1);
                        end
                    end
                    LOCKED: begin
                        if (empty_d) begin
                            if (EMPTY_CNT <= 1) begin
                                state_q  <= IDLE;
                                weight_q <= '0;
                                locked_q <= 1'b0;
                                ecnt_q   <= '0;
                            end else begin
                                state_q <= RELEASING;
                                ecnt_q  <= EW'(1);
                            end
                        end
                    end
                    RELEASING: begin
                        if (!empty_d) begin
                            state_q <= LOCKED;
                            ecnt_q  <= '0;
                        end else if (ecnt_inc_d >= ECNT_REL) begin
                            state_q  <= IDLE;
                            weight_q <= '0;
                            locked_q <= 1'b0;
                            ecnt_q   <= '0;
                        end else begin
                            ecnt_q <= ecnt_inc_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef WSTAB_TIMEOUT_EN
    localparam int unsigned TW = (SETTLE_TMO < 2) ? 1 : $clog2(SETTLE_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SETTLE_TMO - 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_fire_d     = (state_q == SETTLING) && (tmo_q >= TMO_LAST);
    assign bus.settle_err = err_q;

    // Settle timer: counts clocks spent in SETTLING, sticky error on expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == SETTLING) && !tmo_fire_d) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end
            if (tmo_fire_d) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_fire_d     = 1'b0;
    assign bus.settle_err = 1'b0;
`endif

    assign bus.weight     = weight_q;
    assign bus.locked     = locked_q;
    assign bus.pkg_strobe = strobe_q;

endmodule

// File: tb/tb_weight_stabilizer.sv
// tb_weight_stabilizer: table-driven scoreboard bench for weight_stabilizer,
// with a STABLE_CNT=1 second instance and hand sequences for reset and timeout.
module tb_weight_stabilizer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    weight_stabilizer_if bus0 ();
    weight_stabilizer_if bus1 ();

    assign bus1.raw_weight = bus0.raw_weight;
    assign bus1.raw_valid  = bus0.raw_valid;

    weight_stabilizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    weight_stabilizer #(.STABLE_CNT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        bit          v;
        logic [11:0] raw;
        logic [11:0] w;
        bit          lk;
        bit          st;
    } vec_t;

    typedef struct {
        logic [11:0] w;
        bit          lk;
        bit          st;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(bit v, int raw, int w, bit lk, bit st);
        vec_t r;
        r.v   = v;
        r.raw = 12'(raw);
        r.w   = 12'(w);
        r.lk  = lk;
        r.st  = st;
        vecs.push_back(r);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(bit v, int raw);
        @(negedge clk);
        bus0.raw_valid  = v;
        bus0.raw_weight = 12'(raw);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   exp_err;

        reset           = 1'b1;
        bus0.raw_valid  = 1'b0;
        bus0.raw_weight = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.weight", 32'(bus0.weight), 0);
        chk("rst.locked", 32'(bus0.locked), 0);
        chk("rst.strobe", 32'(bus0.pkg_strobe), 0);
        chk("rst.err",    32'(bus0.settle_err), 0);
        chk("rst1.weight", 32'(bus1.weight), 0);
        @(negedge clk);
        reset = 1'b0;

        // STABLE_CNT=1 locks on the first non-empty sample
        cyc(1, 50);
        chk("sc1.weight", 32'(bus1.weight), 50);
        chk("sc1.locked", 32'(bus1.locked), 1);
        chk("sc1.strobe", 32'(bus1.pkg_strobe), 1);
        chk("sc1.dut0_locked", 32'(bus0.locked), 0);
        cyc(0, 50);
        chk("sc1.strobe_drop", 32'(bus1.pkg_strobe), 0);
        chk("sc1.hold", 32'(bus1.weight), 50);
        cyc(1, 0);
        cyc(1, 0);
        chk("sc1.release", 32'(bus1.weight), 0);
        chk("sc1.dut0_weight", 32'(bus0.weight), 0);

        // basic lock 300
        add(1, 300, 0, 0, 0);
        add(1, 302, 0, 0, 0);
        add(1, 299, 0, 0, 0);
        add(1, 305, 300, 1, 1);
        add(0, 0,   300, 1, 0);
        // release with a bounce back
        add(1, 0,   300, 1, 0);
        add(1, 400, 300, 1, 0);
        add(1, 0,   300, 1, 0);
        add(1, 0,   0, 0, 0);
        add(1, 5,   0, 0, 0);
        // reference restart at 320
        add(1, 300, 0, 0, 0);
        add(1, 320, 0, 0, 0);
        add(1, 321, 0, 0, 0);
        add(1, 319, 0, 0, 0);
        add(1, 322, 320, 1, 1);
        add(1, 600, 320, 1, 0);
        add(1, 3,   320, 1, 0);
        add(1, 4,   0, 0, 0);
        // tolerance edge: 8 in, 9 out
        add(1, 300, 0, 0, 0);
        add(1, 308, 0, 0, 0);
        add(1, 292, 0, 0, 0);
        add(1, 309, 0, 0, 0);
        add(1, 301, 0, 0, 0);
        add(1, 317, 0, 0, 0);
        add(1, 309, 309, 1, 1);
        add(1, 0,   309, 1, 0);
        add(1, 0,   0, 0, 0);
        // empty sample during settling
        add(1, 500, 0, 0, 0);
        add(1, 0,   0, 0, 0);
        add(1, 500, 0, 0, 0);
        add(1, 500, 0, 0, 0);
        add(1, 500, 0, 0, 0);
        add(1, 500, 500, 1, 1);
        add(1, 0,   500, 1, 0);
        add(1, 0,   0, 0, 0);
        // valid toggling; invalid cycles ignored
        add(1, 700, 0, 0, 0);
        add(0, 999, 0, 0, 0);
        add(1, 700, 0, 0, 0);
        add(0, 999, 0, 0, 0);
        add(1, 700, 0, 0, 0);
        add(0, 999, 0, 0, 0);
        add(1, 700, 700, 1, 1);
        add(0, 999, 700, 1, 0);
        add(1, 0,   700, 1, 0);
        add(1, 0,   0, 0, 0);
        // far-apart operands must not wrap into the window
        add(1, 4095, 0, 0, 0);
        add(1, 6,    0, 0, 0);
        add(1, 6,    0, 0, 0);
        add(1, 6,    0, 0, 0);
        add(1, 6,    6, 1, 1);
        add(1, 0,    6, 1, 0);
        add(1, 0,    0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus0.raw_valid  = vecs[i].v;
            bus0.raw_weight = vecs[i].raw;
            e.w   = vecs[i].w;
            e.lk  = vecs[i].lk;
            e.st  = vecs[i].st;
            e.idx = i;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            if (sbq.size() == 0) begin
                chk("scoreboard.empty", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("vec%0d.weight", e.idx), 32'(bus0.weight), 32'(e.w));
                chk($sformatf("vec%0d.locked", e.idx), 32'(bus0.locked), 32'(e.lk));
                chk($sformatf("vec%0d.strobe", e.idx), 32'(bus0.pkg_strobe), 32'(e.st));
            end
        end

        // asynchronous reset while locked at 1500
        repeat (4) cyc(1, 1500);
        chk("ar.locked_before", 32'(bus0.locked), 1);
        chk("ar.weight_before", 32'(bus0.weight), 1500);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.weight_async", 32'(bus0.weight), 0);
        chk("ar.locked_async", 32'(bus0.locked), 0);
        @(negedge clk);
        reset          = 1'b0;
        bus0.raw_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ar.strobe_after", 32'(bus0.pkg_strobe), 0);
            chk("ar.weight_after", 32'(bus0.weight), 0);
            chk("ar.locked_after", 32'(bus0.locked), 0);
        end

        // alternating samples never settle
        for (int i = 1; i <= 70; i++) begin
            cyc(1, (i % 2 == 1) ? 100 : 200);
`ifdef WSTAB_TIMEOUT_EN
            exp_err = (i >= 65);
`else
            exp_err = 1'b0;
`endif
            chk($sformatf("tmo.err_clk%0d", i), 32'(bus0.settle_err), 32'(exp_err));
            chk($sformatf("tmo.locked_clk%0d", i), 32'(bus0.locked), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_stabilizer.md
WEIGHT_STABILIZER -- requirements
Module: weight_stabilizer

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive in-tolerance valid samples required to lock.
REQ-002 Parameter TOL, default 8: max |raw_weight - ref| in grams for a sample to count as in-tolerance.
REQ-003 Parameter EMPTY_THR, default 5: raw_weight <= EMPTY_THR counts as an empty-scale sample.
REQ-004 Parameter EMPTY_CNT, default 2: consecutive empty valid samples required to release a lock.
REQ-005 Port clk  input  1: single clock; all state updates on rising edge.
REQ-006 Port reset  input  1: asynchronous, active-high reset.
REQ-007 Port raw_weight  input  12: unsigned scale ADC sample in grams.
REQ-008 Port raw_valid  input  1: raw_weight is a new sample this cycle.
REQ-009 Port weight  output  12: stabilized weight for the sorting stage; 0 when no package is locked.
REQ-010 Port locked  output  1: high while weight holds a locked package value.
REQ-011 Port pkg_strobe  output  1: one-cycle pulse on the cycle locked rises.
REQ-012 Port settle_err  output  1: sticky settle-timeout flag (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE, SETTLING, LOCKED, RELEASING; with raw_valid low, no state, counter or output SHALL change.
REQ-014 IDLE: valid sample > EMPTY_THR -> SETTLING, ref := raw_weight, run := 1; empty sample -> stay.
REQ-015 SETTLING: empty sample -> IDLE; sample with |raw - ref| <= TOL -> run := run + 1; otherwise ref := raw, run := 1.
REQ-016 The absolute difference SHALL be computed at 13 bits with no wrap; raw=0, ref=4095 yields 4095.
REQ-017 When run reaches STABLE_CNT -> LOCKED the same edge; weight := ref, locked := 1, pkg_strobe := 1 for exactly one cycle.
REQ-018 STABLE_CNT = 1 SHALL lock on the first non-empty sample.
REQ-019 LOCKED: weight held constant regardless of non-empty samples; first empty sample -> RELEASING, ecnt := 1.
REQ-020 RELEASING: empty sample increments ecnt; at EMPTY_CNT -> IDLE, weight := 0, locked := 0; non-empty sample -> back to LOCKED, weight unchanged, no new strobe.
REQ-021 weight SHALL be 0 for at least one cycle between any two locks, guaranteeing the downstream sorter sees a zero between packages.
REQ-022 All outputs SHALL be registered; latency from the STABLE_CNT-th sample to weight/locked = 1 clk edge.
REQ-023 Run/empty counters SHALL saturate, never wrap.

Reset
REQ-024 reset high SHALL asynchronously force state IDLE, weight 0, locked 0, pkg_strobe 0, settle_err 0, ref 0, counters 0.
REQ-025 Reset mid-lock SHALL drop weight to 0 immediately; no strobe on release of reset.

Configuration
REQ-026 Macro WSTAB_TIMEOUT_EN defined: parameter SETTLE_TMO (default 64) clk cycles; SETTLING longer than SETTLE_TMO -> IDLE and settle_err := 1 (sticky until reset).
REQ-027 WSTAB_TIMEOUT_EN undefined: no timeout counter; settle_err tied 0; SETTLING unbounded.

Structure
REQ-028 Package wstab_pkg SHALL hold the FSM state enum and default constants STABLE_CNT, TOL, EMPTY_THR, EMPTY_CNT, SETTLE_TMO.
REQ-029 Sub-module wstab_window_cmp SHALL implement the 13-bit |a - b| <= TOL compare; everything else in weight_stabilizer.

Verification
REQ-030 Samples 300,302,299,305 (valid each cycle) -> weight 300, locked 1, one pkg_strobe after 4th sample.
REQ-031 Samples 300,320,321,319,322 -> ref reset at 320; lock to 320 after 5th sample.
REQ-032 Locked at 300, samples 0,400,0,0 -> stays locked at 300 through the 400; weight 0 after final 0; no second strobe.
REQ-033 raw_valid toggling 1/0 with 700 -> lock after 4 valid samples (7 clks); idle cycles do not count.
REQ-034 Assert reset while locked at 1500 -> weight 0, locked 0 same cycle, asynchronously.
REQ-035 WSTAB_TIMEOUT_EN, alternating 100/200 for 70 clks -> settle_err 1 at clk 65, state IDLE; undefined -> settle_err stays 0.
